// File: rtl/ysyx_25030093_axi_pkg.sv
// rtl/ysyx_25030093_axi_pkg.sv - shared types and AXI encodings for the two-master arbiter
package ysyx_25030093_axi_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_M0   = 2'd1,
    R_M1   = 2'd2
  } rd_state_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_BUSY = 1'b1
  } wr_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [2:0] SIZE_B     = 3'd0;
  localparam logic [2:0] SIZE_H     = 3'd1;
  localparam logic [2:0] SIZE_W     = 3'd2;

endpackage

// File: rtl/ysyx_25030093_rr_arb2.sv
// rtl/ysyx_25030093_rr_arb2.sv - two-way round-robin grant with last-winner memory
module ysyx_25030093_rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // 0 means requester 0 won most recently; reset to 1 so requester 0 wins the first tie
  logic last_grant;

  // one-hot grant: a lone requester wins, a tie goes to whoever did not win last
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

  // remember the winner whenever the owner accepts a grant
  always_ff @(posedge clock) begin
    if (!reset) begin
      last_grant <= 1'b1;
    end else if (advance && (req != 2'b00)) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/ysyx_25030093_axi_arbiter.sv
// rtl/ysyx_25030093_axi_arbiter.sv - IFU/LSU to memory AXI4 arbiter, one read and one write in flight
module ysyx_25030093_axi_arbiter
  import ysyx_25030093_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                clock,
  input  logic                reset,
  // m0: instruction fetch, read only
  input  logic                m0_arvalid,
  output logic                m0_arready,
  input  logic [ADDR_W-1:0]   m0_araddr,
  input  logic [ID_W-1:0]     m0_arid,
  input  logic [7:0]          m0_arlen,
  input  logic [2:0]          m0_arsize,
  input  logic [1:0]          m0_arburst,
  output logic                m0_rvalid,
  input  logic                m0_rready,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic [1:0]          m0_rresp,
  output logic [ID_W-1:0]     m0_rid,
  output logic                m0_rlast,
  // m1: load/store unit
  input  logic                m1_arvalid,
  output logic                m1_arready,
  input  logic [ADDR_W-1:0]   m1_araddr,
  input  logic [ID_W-1:0]     m1_arid,
  input  logic [7:0]          m1_arlen,
  input  logic [2:0]          m1_arsize,
  input  logic [1:0]          m1_arburst,
  output logic                m1_rvalid,
  input  logic                m1_rready,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic [1:0]          m1_rresp,
  output logic [ID_W-1:0]     m1_rid,
  output logic                m1_rlast,
  input  logic                m1_awvalid,
  output logic                m1_awready,
  input  logic [ADDR_W-1:0]   m1_awaddr,
  input  logic [ID_W-1:0]     m1_awid,
  input  logic [7:0]          m1_awlen,
  input  logic [2:0]          m1_awsize,
  input  logic [1:0]          m1_awburst,
  input  logic                m1_wvalid,
  output logic                m1_wready,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  input  logic                m1_wlast,
  output logic                m1_bvalid,
  input  logic                m1_bready,
  output logic [1:0]          m1_bresp,
  output logic [ID_W-1:0]     m1_bid,
  // slave side toward memory
  output logic                s_arvalid,
  input  logic                s_arready,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic [ID_W-1:0]     s_arid,
  output logic [7:0]          s_arlen,
  output logic [2:0]          s_arsize,
  output logic [1:0]          s_arburst,
  input  logic                s_rvalid,
  output logic                s_rready,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic [ID_W-1:0]     s_rid,
  input  logic                s_rlast,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic [ID_W-1:0]     s_awid,
  output logic [7:0]          s_awlen,
  output logic [2:0]          s_awsize,
  output logic [1:0]          s_awburst,
  output logic                s_wvalid,
  input  logic                s_wready,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wlast,
  input  logic                s_bvalid,
  output logic                s_bready,
  input  logic [1:0]          s_bresp,
  input  logic [ID_W-1:0]     s_bid
);

  rd_state_e rd_state, rd_next;
  wr_state_e wr_state, wr_next;
  logic       ar_done, aw_done, w_done;
  logic [1:0] arb_req, arb_grant;
  logic       arb_advance, sel_m1, r_done;
  logic       aw_hs, w_hs, b_hs, w_busy;

  assign arb_req = {m1_arvalid, m0_arvalid};

  ysyx_25030093_rr_arb2 u_rd_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (arb_req),
    .advance (arb_advance),
    .grant   (arb_grant)
  );

  // AR payload follows the owner; valid is gated separately so payload muxing is free
  assign sel_m1    = (rd_state == R_M1);
  assign s_araddr  = sel_m1 ? m1_araddr  : m0_araddr;
  assign s_arid    = sel_m1 ? m1_arid    : m0_arid;
  assign s_arlen   = sel_m1 ? m1_arlen   : m0_arlen;
  assign s_arsize  = sel_m1 ? m1_arsize  : m0_arsize;
  assign s_arburst = sel_m1 ? m1_arburst : m0_arburst;

  // R payload fans out to both masters; only the owner ever sees rvalid
  assign m0_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m0_rid   = s_rid;
  assign m0_rlast = s_rlast;
  assign m1_rdata = s_rdata;
  assign m1_rresp = s_rresp;
  assign m1_rid   = s_rid;
  assign m1_rlast = s_rlast;

  assign r_done = s_rvalid & s_rready & s_rlast;

  // read state register
  always_ff @(posedge clock) begin
    if (!reset) rd_state <= R_IDLE;
    else        rd_state <= rd_next;
  end

  // read next-state and handshake routing; a grant holds until the last R beat
  always_comb begin
    rd_next     = rd_state;
    arb_advance = 1'b0;
    s_arvalid   = 1'b0;
    s_rready    = 1'b0;
    m0_arready  = 1'b0;
    m1_arready  = 1'b0;
    m0_rvalid   = 1'b0;
    m1_rvalid   = 1'b0;
    case (rd_state)
      R_IDLE: begin
        arb_advance = 1'b1;
        if (arb_grant[0])      rd_next = R_M0;
        else if (arb_grant[1]) rd_next = R_M1;
      end
      R_M0: begin
        s_arvalid  = m0_arvalid & ~ar_done;
        m0_arready = s_arready & ~ar_done;
        m0_rvalid  = s_rvalid;
        s_rready   = m0_rready;
        if (s_rvalid && m0_rready && s_rlast) rd_next = R_IDLE;
      end
      R_M1: begin
        s_arvalid  = m1_arvalid & ~ar_done;
        m1_arready = s_arready & ~ar_done;
        m1_rvalid  = s_rvalid;
        s_rready   = m1_rready;
        if (s_rvalid && m1_rready && s_rlast) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  // ar_done blocks a second AR from the owner; finishing the burst wins over a same-cycle AR
  always_ff @(posedge clock) begin
    if (!reset) begin
      ar_done <= 1'b0;
    end else if ((rd_state != R_IDLE) && r_done) begin
      ar_done <= 1'b0;
    end else if (s_arvalid && s_arready) begin
      ar_done <= 1'b1;
    end
  end

  // write path: AW/W pass through but each may hand off only once per B
  assign s_awvalid  = m1_awvalid & ~aw_done;
  assign m1_awready = s_awready & ~aw_done;
  assign s_awaddr   = m1_awaddr;
  assign s_awid     = m1_awid;
  assign s_awlen    = m1_awlen;
  assign s_awsize   = m1_awsize;
  assign s_awburst  = m1_awburst;
  assign s_wvalid   = m1_wvalid & ~w_done;
  assign m1_wready  = s_wready & ~w_done;
  assign s_wdata    = m1_wdata;
  assign s_wstrb    = m1_wstrb;
  assign s_wlast    = m1_wlast;
  assign m1_bvalid  = s_bvalid;
  assign s_bready   = m1_bready;
  assign m1_bresp   = s_bresp;
  assign m1_bid     = s_bid;

  assign aw_hs  = s_awvalid & s_awready;
  assign w_hs   = s_wvalid & s_wready;
  assign b_hs   = s_bvalid & s_bready;
  assign w_busy = (wr_state == W_BUSY);

  // write state register
  always_ff @(posedge clock) begin
    if (!reset) wr_state <= W_IDLE;
    else        wr_state <= wr_next;
  end

  // write next-state: busy from the first AW or W handshake until B
  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (aw_hs || w_hs) wr_next = W_BUSY;
      W_BUSY:  if (b_hs)          wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  // per-channel done flags, released together when the response retires
  always_ff @(posedge clock) begin
    if (!reset) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (w_busy && b_hs) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ysyx_25030093_axi_arbiter.sv
// tb/tb_ysyx_25030093_axi_arbiter.sv - self-checking bench for the two-master AXI arbiter
module tb_ysyx_25030093_axi_arbiter;
  import ysyx_25030093_axi_pkg::*;

  logic        clock, reset;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_rlast;
  logic [31:0] m0_araddr, m0_rdata;
  logic [3:0]  m0_arid, m0_rid;
  logic [7:0]  m0_arlen;
  logic [2:0]  m0_arsize;
  logic [1:0]  m0_arburst, m0_rresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_rlast;
  logic [31:0] m1_araddr, m1_rdata;
  logic [3:0]  m1_arid, m1_rid;
  logic [7:0]  m1_arlen;
  logic [2:0]  m1_arsize;
  logic [1:0]  m1_arburst, m1_rresp;
  logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_wlast, m1_bvalid, m1_bready;
  logic [31:0] m1_awaddr, m1_wdata;
  logic [3:0]  m1_awid, m1_wstrb, m1_bid;
  logic [7:0]  m1_awlen;
  logic [2:0]  m1_awsize;
  logic [1:0]  m1_awburst, m1_bresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [31:0] s_araddr, s_rdata;
  logic [3:0]  s_arid, s_rid;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst, s_rresp;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0]  s_awid, s_wstrb, s_bid;
  logic [7:0]  s_awlen;
  logic [2:0]  s_awsize;
  logic [1:0]  s_awburst, s_bresp;

  int n_chk = 0;
  int n_err = 0;

  ysyx_25030093_axi_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
    .clock(clock), .reset(reset),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arid(m0_arid),
    .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
    .m0_rid(m0_rid), .m0_rlast(m0_rlast),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arid(m1_arid),
    .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
    .m1_rid(m1_rid), .m1_rlast(m1_rlast),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid),
    .m1_awlen(m1_awlen), .m1_awsize(m1_awsize), .m1_awburst(m1_awburst),
    .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_wlast(m1_wlast), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
    .m1_bid(m1_bid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rid(s_rid), .s_rlast(s_rlast),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic zero_inputs();
    {m0_arvalid, m0_rready, m1_arvalid, m1_rready} = '0;
    m0_araddr = '0; m0_arid = '0; m0_arlen = '0; m0_arsize = SIZE_W; m0_arburst = BURST_INCR;
    m1_araddr = '0; m1_arid = '0; m1_arlen = '0; m1_arsize = SIZE_W; m1_arburst = BURST_INCR;
    {m1_awvalid, m1_wvalid, m1_wlast, m1_bready} = '0;
    m1_awaddr = '0; m1_awid = '0; m1_awlen = '0; m1_awsize = SIZE_W; m1_awburst = BURST_INCR;
    m1_wdata = '0; m1_wstrb = '0;
    {s_arready, s_rvalid, s_rlast, s_awready, s_wready, s_bvalid} = '0;
    s_rdata = '0; s_rresp = RESP_OKAY; s_rid = '0; s_bresp = RESP_OKAY; s_bid = '0;
  endtask

  function automatic logic [11:0] all_handshake_outs();
    return {s_arvalid, s_rready, m0_arready, m0_rvalid, m1_arready, m1_rvalid,
            s_awvalid, s_wvalid, s_bready, m1_awready, m1_wready, m1_bvalid};
  endfunction

  function automatic logic [5:0] rd_ctl();
    return {s_arvalid, m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_rready};
  endfunction

  // slave read-data pattern, keyed by address and beat so misrouted bursts show up
  function automatic logic [31:0] beat_data(input logic [31:0] a, input int b);
    return a ^ (32'(b) << 24) ^ 32'h0000_5A5A;
  endfunction

  // in_ctl = {m0_arvalid, m1_arvalid, s_arready, s_rvalid, s_rlast, m0_rready, m1_rready}
  // exp    = {s_arvalid, m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_rready}
  typedef struct {
    logic [6:0]  in_ctl;
    logic [31:0] m0a, m1a, srd;
    logic [5:0]  exp;
    logic [31:0] exp_addr, exp_data;
  } vec_t;

  vec_t tbl[14];

  // random-phase state: masters, slave and the arbitration reference
  bit          mv[2], waiting[2], rr[2];
  logic [31:0] maddr[2];
  logic [3:0]  mid[2];
  logic [7:0]  mlen[2];
  int          mbeat[2];
  bit          sl_busy, sl_rv;
  logic [31:0] sl_addr;
  logic [3:0]  sl_id;
  logic [7:0]  sl_len;
  int          sl_beat;
  int          owner, last_win, reads_done;
  int          aw_cnt, w_cnt, b_cnt;

  initial begin
    reset = 1'b0;
    zero_inputs();
    step();
    #2;
    check("reset_outputs", all_handshake_outs(), 12'h000);
    step();
    reset = 1'b1;

    // single m1 read, two round-robin ties, then a lone m0 request
    tbl[0]  = '{7'b0100000, 32'h8000_0100, 32'h8000_0004, 32'h0,         6'b000000, 32'h0,         32'h0};
    tbl[1]  = '{7'b0110000, 32'h8000_0100, 32'h8000_0004, 32'h0,         6'b101000, 32'h8000_0004, 32'h0};
    tbl[2]  = '{7'b0001101, 32'h8000_0100, 32'h8000_0004, 32'hDEAD_BEEF, 6'b000011, 32'h0,         32'hDEAD_BEEF};
    tbl[3]  = '{7'b0000000, 32'h8000_0100, 32'h8000_0200, 32'h0,         6'b000000, 32'h0,         32'h0};
    tbl[4]  = '{7'b1100000, 32'h8000_0100, 32'h8000_0200, 32'h0,         6'b000000, 32'h0,         32'h0};
    tbl[5]  = '{7'b1110000, 32'h8000_0100, 32'h8000_0200, 32'h0,         6'b110000, 32'h8000_0100, 32'h0};
    tbl[6]  = '{7'b0101110, 32'h8000_0100, 32'h8000_0200, 32'h1111_1111, 6'b000101, 32'h0,         32'h1111_1111};
    tbl[7]  = '{7'b1100000, 32'h8000_0300, 32'h8000_0200, 32'h0,         6'b000000, 32'h0,         32'h0};
    tbl[8]  = '{7'b1110000, 32'h8000_0300, 32'h8000_0200, 32'h0,         6'b101000, 32'h8000_0200, 32'h0};
    tbl[9]  = '{7'b1001101, 32'h8000_0300, 32'h8000_0200, 32'h2222_2222, 6'b000011, 32'h0,         32'h2222_2222};
    tbl[10] = '{7'b1000000, 32'h8000_0300, 32'h8000_0200, 32'h0,         6'b000000, 32'h0,         32'h0};
    tbl[11] = '{7'b1010000, 32'h8000_0300, 32'h8000_0200, 32'h0,         6'b110000, 32'h8000_0300, 32'h0};
    tbl[12] = '{7'b0001110, 32'h8000_0300, 32'h8000_0200, 32'h3333_3333, 6'b000101, 32'h0,         32'h3333_3333};
    tbl[13] = '{7'b0000000, 32'h8000_0300, 32'h8000_0200, 32'h0,         6'b000000, 32'h0,         32'h0};

    for (int i = 0; i < 14; i++) begin
      step();
      {m0_arvalid, m1_arvalid, s_arready, s_rvalid, s_rlast, m0_rready, m1_rready} = tbl[i].in_ctl;
      m0_araddr = tbl[i].m0a;
      m1_araddr = tbl[i].m1a;
      s_rdata   = tbl[i].srd;
      #2;
      check($sformatf("tbl%0d_ctl", i), rd_ctl(), tbl[i].exp);
      if (tbl[i].exp[5]) check($sformatf("tbl%0d_araddr", i), s_araddr, tbl[i].exp_addr);
      if (tbl[i].exp[2]) check($sformatf("tbl%0d_m0_rdata", i), m0_rdata, tbl[i].exp_data);
      if (tbl[i].exp[1]) check($sformatf("tbl%0d_m1_rdata", i), m1_rdata, tbl[i].exp_data);
    end

    // m0 four-beat burst; m1 requests from beat 1 and must wait out the whole burst
    step(); zero_inputs();
    m0_arvalid = 1'b1; m0_araddr = 32'h8000_1000; m0_arlen = 8'd3;
    #2; check("burst_grant_latency", s_arvalid, 1'b0);
    step(); s_arready = 1'b1;
    #2; check("burst_m0_ar", {s_arvalid, m0_arready, s_araddr, s_arlen}, {2'b11, 32'h8000_1000, 8'd3});
    for (int b = 0; b < 4; b++) begin
      step();
      m0_arvalid = 1'b0; s_arready = 1'b0; m0_rready = 1'b1;
      s_rvalid = 1'b1; s_rlast = (b == 3); s_rdata = 32'hB000_0000 | 32'(b);
      m1_arvalid = (b >= 1); m1_araddr = 32'h8000_2000;
      #2;
      check($sformatf("burst_m1_held_b%0d", b), {m1_arready, s_arvalid}, 2'b00);
      check($sformatf("burst_m0_beat%0d", b), {m0_rvalid, m1_rvalid, m0_rdata}, {2'b10, 32'hB000_0000 | 32'(b)});
    end
    step(); s_rvalid = 1'b0; s_rlast = 1'b0; m0_rready = 1'b0;
    #2; check("burst_bubble", {s_arvalid, m1_arready}, 2'b00);
    step(); s_arready = 1'b1;
    #2; check("burst_m1_grant", {s_arvalid, m1_arready, s_araddr}, {2'b11, 32'h8000_2000});
    step(); m1_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b1;
    s_rdata = 32'hC0C0_C0C0; m1_rready = 1'b1;
    #2; check("burst_m1_data", {m1_rvalid, m1_rdata}, {1'b1, 32'hC0C0_C0C0});

    // reset asserted after AR, before rlast; then a fresh m0 read
    step(); zero_inputs();
    m0_arvalid = 1'b1; m0_araddr = 32'h8000_3000;
    step(); s_arready = 1'b1;
    #2; check("rst_mid_ar", s_arvalid, 1'b1);
    step(); m0_arvalid = 1'b0; s_arready = 1'b0; reset = 1'b0; s_rvalid = 1'b1; m0_rready = 1'b1;
    step(); reset = 1'b1; m0_arvalid = 1'b1;
    #2; check("rst_mid_idle", all_handshake_outs(), 12'h000);
    step(); s_rvalid = 1'b0; s_arready = 1'b1;
    #2; check("rst_fresh_ar", {s_arvalid, m0_arready, s_araddr}, {2'b11, 32'h8000_3000});
    step(); m0_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 32'h4444_4444;
    #2; check("rst_fresh_data", {m0_rvalid, m0_rdata}, {1'b1, 32'h4444_4444});

    // LSU store: AW two cycles ahead of W, a second AW held until B retires
    step(); zero_inputs();
    aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    m1_awvalid = 1'b1; m1_awaddr = 32'h8000_0008; s_awready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        step();
        m1_awaddr = 32'h8000_000C;
      end
      m1_wvalid = (c == 2); m1_wlast = (c == 2); m1_wdata = 32'h0BAD_F00D; m1_wstrb = 4'hF;
      s_wready = (c == 2);
      s_bvalid = (c == 3); m1_bready = (c == 3); s_bresp = RESP_OKAY; s_bid = 4'h3;
      #2;
      aw_cnt += int'(s_awvalid && s_awready);
      w_cnt  += int'(s_wvalid && s_wready);
      b_cnt  += int'(m1_bvalid && m1_bready);
      if (c > 0) check($sformatf("wr_aw_blocked_c%0d", c), {s_awvalid, m1_awready}, 2'b00);
    end
    check("wr_counts", {aw_cnt[7:0], w_cnt[7:0], b_cnt[7:0]}, {8'd1, 8'd1, 8'd1});
    check("wr_bresp", m1_bresp, RESP_OKAY);
    step(); s_bvalid = 1'b0; m1_bready = 1'b0;
    #2; check("wr_second_aw", {s_awvalid, m1_awready, s_awaddr}, {2'b11, 32'h8000_000C});
    step(); m1_awvalid = 1'b0; m1_wvalid = 1'b1; m1_wlast = 1'b1; s_wready = 1'b1;
    step(); m1_wvalid = 1'b0; s_bvalid = 1'b1; m1_bready = 1'b1;
    step(); zero_inputs();

    // randomized reads from both masters against a transaction-level model
    reset = 1'b0;
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mv[i] = 0; waiting[i] = 0; rr[i] = 0; maddr[i] = '0; mid[i] = '0; mlen[i] = '0; mbeat[i] = 0;
    end
    sl_busy = 0; sl_rv = 0; sl_addr = '0; sl_id = '0; sl_len = '0; sl_beat = 0;
    owner = -1; last_win = 1; reads_done = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit exp_srv, rl_hs;
      step();
      for (int i = 0; i < 2; i++) begin
        if (!mv[i] && !waiting[i] && $urandom_range(0, 2) == 0) begin
          mv[i] = 1; maddr[i] = $urandom & 32'hFFFF_FFFC; mid[i] = 4'($urandom);
          mlen[i] = 8'($urandom_range(0, 3)); mbeat[i] = 0;
        end
        rr[i] = ($urandom_range(0, 3) != 0);
      end
      if (sl_busy && !sl_rv && $urandom_range(0, 1) == 1) sl_rv = 1;
      s_arready  = 1'($urandom_range(0, 1));
      m0_arvalid = mv[0]; m0_araddr = maddr[0]; m0_arid = mid[0]; m0_arlen = mlen[0]; m0_rready = rr[0];
      m1_arvalid = mv[1]; m1_araddr = maddr[1]; m1_arid = mid[1]; m1_arlen = mlen[1]; m1_rready = rr[1];
      s_rvalid = sl_rv; s_rdata = beat_data(sl_addr, sl_beat); s_rlast = (sl_beat == int'(sl_len));
      s_rid = sl_id; s_rresp = 2'(sl_beat);
      #2;
      exp_srv = (owner == 0 && mv[0]) || (owner == 1 && mv[1]);
      check("rnd_route", rd_ctl(),
            {exp_srv, owner == 0 && mv[0] && s_arready, owner == 1 && mv[1] && s_arready,
             owner == 0 && sl_rv, owner == 1 && sl_rv, (owner == 0 && rr[0]) || (owner == 1 && rr[1])});
      rl_hs = (owner >= 0) && sl_rv && rr[owner] && (sl_beat == int'(sl_len));
      if (owner >= 0 && s_arvalid && s_arready) begin
        check("rnd_ar_payload", {s_araddr, s_arid, s_arlen}, {maddr[owner], mid[owner], mlen[owner]});
        check("rnd_one_in_flight", sl_busy, 1'b0);
        sl_busy = 1; sl_addr = s_araddr; sl_id = s_arid; sl_len = s_arlen; sl_beat = 0;
        mv[owner] = 0; waiting[owner] = 1;
      end
      for (int i = 0; i < 2; i++) begin
        if (waiting[i] && ((i == 0) ? (m0_rvalid && m0_rready) : (m1_rvalid && m1_rready))) begin
          check($sformatf("rnd_m%0d_beat", i),
                (i == 0) ? {m0_rdata, m0_rresp, m0_rid, m0_rlast} : {m1_rdata, m1_rresp, m1_rid, m1_rlast},
                {beat_data(maddr[i], mbeat[i]), 2'(mbeat[i]), mid[i], mbeat[i] == int'(mlen[i])});
          if (mbeat[i] == int'(mlen[i])) begin
            waiting[i] = 0;
            reads_done++;
          end
          mbeat[i]++;
        end
      end
      if (sl_rv && s_rready) begin
        if (sl_beat == int'(sl_len)) sl_busy = 0;
        sl_rv = 0;
        sl_beat++;
      end
      if (owner < 0) begin
        if (mv[0] && mv[1]) owner = (last_win == 1) ? 0 : 1;
        else if (mv[0])     owner = 0;
        else if (mv[1])     owner = 1;
        if (owner >= 0) last_win = owner;
      end else if (rl_hs) begin
        owner = -1;
      end
    end
    check("rnd_progress", reads_done > 100, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_25030093_axi_arbiter.md
# ysyx_25030093_axi_arbiter

Two-master, one-slave AXI4 arbiter that sits directly downstream of the core's load/store unit and instruction fetch unit and feeds the single memory-side AXI4 port. Read requests from both masters are arbitrated round-robin, one transaction in flight at a time. Writes come only from the load/store unit and pass through under a tracked single-outstanding rule.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `ID_W`, default 4: AXI ID width.
- `clock` in 1: the only clock.
- `reset` in 1: synchronous, active-low.
- `m0_ar*` in/out: IFU read address. `arvalid`/`arready` 1 bit, `araddr` ADDR_W, `arid` ID_W, `arlen` 8, `arsize` 3, `arburst` 2.
- `m0_r*` out/in: IFU read data. `rvalid`/`rready`/`rlast` 1 bit, `rdata` DATA_W, `rresp` 2, `rid` ID_W.
- `m1_ar*`, `m1_r*`: LSU read channels, same shape as m0.
- `m1_aw*`, `m1_w*`, `m1_b*`: LSU write channels.
  - `aw`: valid/ready, addr, id, len, size, burst.
  - `w`: valid/ready, data DATA_W, strb DATA_W/8, last.
  - `b`: valid/ready, resp 2, id ID_W.
- `s_ar*`, `s_r*`, `s_aw*`, `s_w*`, `s_b*`: slave-side mirror of the above, toward memory.

## Operation
- Read FSM states: `R_IDLE`, `R_M0`, `R_M1`. Flag `ar_done`. Register `last_grant`, where 0 means m0 was granted last.
- `R_IDLE`:
  - Only m0_arvalid high: go to `R_M0`.
  - Only m1_arvalid high: go to `R_M1`.
  - Both high: grant the master ≠ last_grant, and update last_grant.
  - Neither high: stay.
  - In this state all master arready/rvalid = 0 and s_arvalid = 0.
- `R_Mx` AR routing:
  - s_ar* = mx_ar*, with s_arvalid = mx_arvalid & ~ar_done.
  - mx_arready = s_arready & ~ar_done.
  - On s_arvalid & s_arready, set ar_done.
- `R_Mx` R routing:
  - mx_r* = s_r*, and s_rready = mx_rready.
  - The other master sees arready = 0 and rvalid = 0.
- `R_Mx` exit: on s_rvalid & s_rready & s_rlast, go to `R_IDLE` and clear ar_done.
- rresp and rid are forwarded unchanged. Errors do not alter the FSM.
- Write path: one write in flight, tracked by `w_busy` and states `W_IDLE` / `W_BUSY`.
  - AW and W pass through combinationally to s_aw*/s_w*, gated so that s_awvalid = m1_awvalid & ~aw_done and s_wvalid = m1_wvalid & ~w_done (`aw_done` / `w_done` set on the respective handshake).
  - B passes through.
  - Enter `W_BUSY` on the first AW or W handshake.
  - Return to `W_IDLE` on s_bvalid & s_bready, clearing aw_done and w_done.
- Read/write ordering: reads and writes are independent. m1 is responsible for ordering its own load-after-store, and it already waits for B before retiring.

## Timing
- Reset (reset = 0 at a clock edge):
  - Read FSM goes to `R_IDLE`, write FSM to `W_IDLE`.
  - ar_done, aw_done and w_done clear; last_grant = 1, so m0 wins the first tie.
  - All valid/ready outputs read 0 the cycle after reset is sampled.
  - Reset mid-burst abandons the transaction; no recovery is attempted.
- Grant latency: arvalid sampled in `R_IDLE` at edge N; the AR forward to s_ar* is visible from cycle N+1.
- Earliest re-grant: the cycle after the rlast handshake, i.e. one idle bubble per read.
- A master must hold arvalid and its payload stable until arready. Arbitration never revokes a grant before rlast.
- Bursts: any arlen is supported. The FSM waits only on rlast, not on a beat count.
- Simultaneous events:
  - AR handshake and first R beat in the same cycle are legal.
  - A new arvalid from the other master during `R_Mx` is held off (arready = 0) until return to `R_IDLE`.
- All master-side outputs are combinational from state plus slave inputs. No extra register stage is added.

## Structure
- Package `ysyx_25030093_axi_pkg`: read-state enum, write-state enum, BURST_INCR = 2'b01, RESP_OKAY = 2'b00, SIZE_B/H/W = 0/1/2.
- Sub-module `ysyx_25030093_rr_arb2`:
  - Inputs req[1:0] and an advance strobe; output a one-hot grant.
  - Owns last_grant.
  - Instantiated once, for the read path.

## Test plan
- Reset, then only m1 issues AR to 0x8000_0004, len 0:
  - s_araddr = 0x8000_0004 one cycle after request.
  - m1_rdata = 0xDEADBEEF on rlast.
  - m0 sees no rvalid.
- m0 and m1 assert arvalid in the same cycle, twice in a row:
  - First grant goes to m0, second to m1 (round-robin).
  - One idle cycle between them.
- m0 burst arlen = 3 with m1 arvalid raised on beat 1:
  - m1_arready stays 0 until m0's 4th beat with rlast.
  - m1 is granted the following cycle.
- m1 sw: AW arrives 2 cycles before W, slave answers bresp = 0:
  - Each of s_awvalid and s_wvalid handshakes exactly once.
  - m1_bvalid is seen once.
  - A second AW is blocked until B completes.
- reset = 0 asserted mid-read (after AR, before rlast):
  - Next cycle all valids are 0 and FSM is `R_IDLE`.
  - A fresh m0 request after reset is served normally.
